// File: rtl/rfft_pkg.sv
// Shared parameters and state encoding for the RFFT sequencer slice.
package rfft_pkg;
  localparam int unsigned ADDR_W = 6;
  localparam int unsigned NSTAGE = 7;
  localparam int unsigned PE_LAT = 2;
  localparam int unsigned RD_LAT = 1;
  localparam int unsigned LAT    = RD_LAT + PE_LAT;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;
endpackage

// File: rtl/rfft_addr_gen.sv
// Combinational per-stage address transforms: partner address, crossbar selects, twiddle index.
module rfft_addr_gen
  import rfft_pkg::*;
(
  input  logic [2:0]        i_stage,
  input  logic [ADDR_W-1:0] i_cnt,
  input  logic [ADDR_W-1:0] i_cnt_d,
  output logic [ADDR_W-1:0] o_rd_addr_b,
  output logic              o_rd_swap,
  output logic              o_wr_swap,
  output logic [ADDR_W-1:0] o_tf_addr
);
  logic [ADDR_W-1:0] w_mask;

  // Bit selects are resolved by matching index against stage so that out-of-range
  // selects (stage 0 read side, last stage write side) naturally yield 0.
  always_comb begin
    w_mask    = '0;
    o_rd_swap = 1'b0;
    o_wr_swap = 1'b0;
    for (int unsigned i = 0; i < ADDR_W; i++) begin
      if (i + 32'(i_stage) >= ADDR_W)
        w_mask[i] = 1'b1;
      if (i_stage != 3'd0 && i + 32'(i_stage) == ADDR_W)
        o_rd_swap = i_cnt[i];
      if (i + 32'(i_stage) == ADDR_W - 1)
        o_wr_swap = i_cnt_d[i];
    end
    o_rd_addr_b = i_cnt ^ w_mask;
    o_tf_addr   = i_cnt << i_stage;
  end
endmodule

// File: rtl/rfft_seq_ctrl.sv
// Stage/address sequencer for the 4-bank in-place radix-2 RFFT; write-back delayed by LAT.
module rfft_seq_ctrl
  import rfft_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [2:0]        stage,
  output logic [ADDR_W-1:0] rd_addr_a,
  output logic [ADDR_W-1:0] rd_addr_b,
  output logic [ADDR_W-1:0] wr_addr_a,
  output logic [ADDR_W-1:0] wr_addr_b,
  output logic [3:0]        we,
  output logic              rd_swap,
  output logic              wr_swap,
  output logic [ADDR_W-1:0] tf_addr,
  output logic              bypass_n
);
  localparam int unsigned DRAIN_W = (LAT > 1) ? $clog2(LAT) : 1;

  logic                r_rst_meta, r_rst_sync;
  logic                w_rst_n;
  state_e              r_state, w_state_nx;
  logic [ADDR_W-1:0]   r_cnt, w_cnt_nx;
  logic [DRAIN_W-1:0]  r_drain, w_drain_nx;
  logic [2:0]          r_stage, w_stage_nx;
  logic [ADDR_W-1:0]   r_dly_a [LAT];
  logic [ADDR_W-1:0]   r_dly_b [LAT];
  logic [LAT-1:0]      r_dly_v;
  logic                w_run;
  logic [ADDR_W-1:0]   w_rd_b, w_tf;
  logic                w_rd_swap, w_wr_swap;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_rst_meta <= 1'b0;
      r_rst_sync <= 1'b0;
    end else begin
      r_rst_meta <= 1'b1;
      r_rst_sync <= r_rst_meta;
    end
  end
  assign w_rst_n = r_rst_sync;

  always_ff @(posedge Clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_drain <= '0;
      r_stage <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_drain <= w_drain_nx;
      r_stage <= w_stage_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_drain_nx = r_drain;
    w_stage_nx = r_stage;
    case (r_state)
      IDLE: if (start) begin
        w_state_nx = RUN;
        w_cnt_nx   = '0;
      end
      RUN: begin
        w_cnt_nx = r_cnt + 1'b1;
        if (r_cnt == '1) begin
          w_state_nx = DRAIN;
          w_drain_nx = '0;
        end
      end
      DRAIN: begin
        if (r_drain == DRAIN_W'(LAT - 1)) begin
          if (r_stage == 3'(NSTAGE - 1)) begin
            w_state_nx = DONE;
            w_stage_nx = '0;
          end else begin
            w_state_nx = RUN;
            w_stage_nx = r_stage + 3'd1;
          end
        end else begin
          w_drain_nx = r_drain + 1'b1;
        end
      end
      DONE:    w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  assign w_run = (r_state == RUN);

  // rd_addr_a equals cnt during RUN, so the delayed A address doubles as cnt_d.
  rfft_addr_gen u_addr_gen (
    .i_stage     (r_stage),
    .i_cnt       (r_cnt),
    .i_cnt_d     (r_dly_a[LAT-1]),
    .o_rd_addr_b (w_rd_b),
    .o_rd_swap   (w_rd_swap),
    .o_wr_swap   (w_wr_swap),
    .o_tf_addr   (w_tf)
  );

  always_ff @(posedge Clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      for (int unsigned i = 0; i < LAT; i++) begin
        r_dly_a[i] <= '0;
        r_dly_b[i] <= '0;
      end
      r_dly_v <= '0;
    end else begin
      r_dly_a[0] <= rd_addr_a;
      r_dly_b[0] <= rd_addr_b;
      for (int unsigned i = 1; i < LAT; i++) begin
        r_dly_a[i] <= r_dly_a[i-1];
        r_dly_b[i] <= r_dly_b[i-1];
      end
      r_dly_v <= {r_dly_v[LAT-2:0], w_run};
    end
  end

  assign busy      = (r_state != IDLE);
  assign done      = (r_state == DONE);
  assign stage     = r_stage;
  assign rd_addr_a = w_run ? r_cnt : '0;
  assign rd_addr_b = w_run ? w_rd_b : '0;
  assign rd_swap   = w_run & w_rd_swap;
  assign tf_addr   = w_run ? w_tf : '0;
  assign bypass_n  = (w_run || r_state == DRAIN) && (r_stage != 3'(NSTAGE - 1));
  assign we        = {4{r_dly_v[LAT-1]}};
  assign wr_addr_a = r_dly_a[LAT-1];
  assign wr_addr_b = r_dly_b[LAT-1];
  assign wr_swap   = r_dly_v[LAT-1] & w_wr_swap;
endmodule

// File: tb/tb_rfft_seq_ctrl.sv
// Directed bench for the RFFT sequencer: timing, addressing, write window, start filtering, reset abort.
module tb_rfft_seq_ctrl;
  logic       Clk = 1'b0;
  logic       Reset_n;
  logic       start;
  logic       busy, done, rd_swap, wr_swap, bypass_n;
  logic [2:0] stage;
  logic [5:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b, tf_addr;
  logic [3:0] we;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  rfft_seq_ctrl dut (
    .Clk(Clk), .Reset_n(Reset_n), .start(start), .busy(busy), .done(done),
    .stage(stage), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b), .we(we),
    .rd_swap(rd_swap), .wr_swap(wr_swap), .tf_addr(tf_addr), .bypass_n(bypass_n)
  );

  task automatic do_reset();
    start   = 1'b0;
    Reset_n = 1'b0;
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
    repeat (4) @(negedge Clk);
  endtask

  // Called at a negedge: start is high across the accepting edge, returns in cycle 1.
  task automatic launch();
    start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    logic [48:0] all_out;
    start   = 1'b0;
    Reset_n = 1'b0;
    @(negedge Clk);
    #1;
    all_out = {busy, done, stage, rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b, we,
               rd_swap, wr_swap, tf_addr, bypass_n};
    checks++;
    if (all_out !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %h exp 0", all_out);
    end
    Reset_n = 1'b1;
    repeat (4) @(negedge Clk);
    checks++;
    if (busy !== 1'b0 || we !== 4'h0 || bypass_n !== 1'b0 || rd_addr_a !== 6'h0) begin
      errors++;
      $display("FAIL idle_after_reset got busy=%b we=%h byp=%b rda=%h exp 0", busy, we, bypass_n, rd_addr_a);
    end
  endtask

  task automatic test_timing();
    launch();
    for (int c = 1; c <= 472; c++) begin
      checks++;
      if (busy !== (c <= 470)) begin
        errors++;
        $display("FAIL timing_busy cyc %0d got %b exp %b", c, busy, (c <= 470));
      end
      checks++;
      if (done !== (c == 470)) begin
        errors++;
        $display("FAIL timing_done cyc %0d got %b exp %b", c, done, (c == 470));
      end
      @(negedge Clk);
    end
  endtask

  task automatic test_addressing();
    int s, k, mask, exp_b, exp_sw, exp_tf;
    launch();
    for (int c = 1; c <= 469; c++) begin
      s = (c - 1) / 67;
      k = (c - 1) % 67;
      if (c == 140) begin
        checks++;
        if (stage !== 3'd2 || rd_addr_a !== 6'h05 || rd_addr_b !== 6'h35 || rd_swap !== 1'b0 ||
            tf_addr !== 6'h14 || bypass_n !== 1'b1) begin
          errors++;
          $display("FAIL addr_stage2_cnt5 got st=%0d a=%h b=%h sw=%b tf=%h byp=%b exp 2 05 35 0 14 1",
                   stage, rd_addr_a, rd_addr_b, rd_swap, tf_addr, bypass_n);
        end
      end
      if (c == 408) begin
        checks++;
        if (stage !== 3'd6 || rd_addr_b !== 6'h3A || bypass_n !== 1'b0 || rd_swap !== 1'b1 ||
            tf_addr !== 6'h00) begin
          errors++;
          $display("FAIL addr_stage6_cnt5 got st=%0d b=%h byp=%b sw=%b tf=%h exp 6 3a 0 1 00",
                   stage, rd_addr_b, bypass_n, rd_swap, tf_addr);
        end
      end
      checks++;
      if (stage !== 3'(s)) begin
        errors++;
        $display("FAIL addr_stage cyc %0d got %0d exp %0d", c, stage, s);
      end
      if (k < 64) begin
        mask = 0;
        for (int i = 0; i < 6; i++) if (i >= 6 - s) mask |= (1 << i);
        exp_b  = k ^ mask;
        exp_sw = (s == 0) ? 0 : ((k >> (6 - s)) & 1);
        exp_tf = (k << s) & 63;
        checks++;
        if (rd_addr_a !== 6'(k) || rd_addr_b !== 6'(exp_b) || rd_swap !== 1'(exp_sw) ||
            tf_addr !== 6'(exp_tf)) begin
          errors++;
          $display("FAIL addr_run cyc %0d got a=%h b=%h sw=%b tf=%h exp %h %h %0d %h",
                   c, rd_addr_a, rd_addr_b, rd_swap, tf_addr, k, exp_b, exp_sw, exp_tf);
        end
      end else begin
        checks++;
        if (rd_addr_a !== 6'h0 || rd_addr_b !== 6'h0) begin
          errors++;
          $display("FAIL addr_drain_idle cyc %0d got a=%h b=%h exp 0 0", c, rd_addr_a, rd_addr_b);
        end
      end
      @(negedge Clk);
    end
    repeat (3) @(negedge Clk);
  endtask

  task automatic test_write_window();
    int ha [0:511];
    int hb [0:511];
    int we_cnt [7];
    int total, s, k, exp_sw;
    logic exp_we;
    total = 0;
    for (int i = 0; i < 7; i++) we_cnt[i] = 0;
    launch();
    for (int c = 1; c <= 472; c++) begin
      s = (c - 1) / 67;
      k = (c - 1) % 67;
      ha[c] = int'(rd_addr_a);
      hb[c] = int'(rd_addr_b);
      exp_we = (c <= 469) && (k >= 3);
      checks++;
      if (we !== {4{exp_we}}) begin
        errors++;
        $display("FAIL we_window cyc %0d got %h exp %h", c, we, {4{exp_we}});
      end
      if (we !== 4'h0 && c >= 4 && s < 7) begin
        we_cnt[s]++;
        total++;
        exp_sw = (s < 6) ? (((k - 3) >> (5 - s)) & 1) : 0;
        checks++;
        if (wr_addr_a !== 6'(ha[c-3]) || wr_addr_b !== 6'(hb[c-3]) || wr_swap !== 1'(exp_sw)) begin
          errors++;
          $display("FAIL wr_addr cyc %0d got a=%h b=%h sw=%b exp %h %h %0d",
                   c, wr_addr_a, wr_addr_b, wr_swap, ha[c-3], hb[c-3], exp_sw);
        end
      end
      @(negedge Clk);
    end
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (we_cnt[i] != 64) begin
        errors++;
        $display("FAIL we_count_stage%0d got %0d exp 64", i, we_cnt[i]);
      end
    end
    checks++;
    if (total != 448) begin
      errors++;
      $display("FAIL we_count_total got %0d exp 448", total);
    end
  endtask

  task automatic test_ignored_start();
    launch();
    for (int c = 1; c <= 480; c++) begin
      checks++;
      if (busy !== (c <= 470) || done !== (c == 470)) begin
        errors++;
        $display("FAIL ignored_start cyc %0d got busy=%b done=%b exp %b %b",
                 c, busy, done, (c <= 470), (c == 470));
      end
      start = (c == 10 || c == 200 || c == 470);
      @(negedge Clk);
    end
    start = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic exp_busy;
    start = 1'b1;
    @(negedge Clk);
    for (int c = 1; c <= 945; c++) begin
      exp_busy = (c <= 470) || (c >= 472 && c <= 941);
      checks++;
      if (busy !== exp_busy || done !== (c == 470 || c == 941)) begin
        errors++;
        $display("FAIL back_to_back cyc %0d got busy=%b done=%b exp %b %b",
                 c, busy, done, exp_busy, (c == 470 || c == 941));
      end
      if (c == 941) start = 1'b0;
      @(negedge Clk);
    end
    start = 1'b0;
  endtask

  task automatic test_mid_reset();
    launch();
    repeat (149) @(negedge Clk);
    checks++;
    if (we !== 4'hF || stage !== 3'd2 || busy !== 1'b1) begin
      errors++;
      $display("FAIL midreset_pre got we=%h st=%0d busy=%b exp f 2 1", we, stage, busy);
    end
    Reset_n = 1'b0;
    #1;
    checks++;
    if (we !== 4'h0 || busy !== 1'b0 || stage !== 3'd0 || done !== 1'b0) begin
      errors++;
      $display("FAIL midreset_async got we=%h busy=%b st=%0d done=%b exp 0 0 0 0", we, busy, stage, done);
    end
    for (int c = 0; c < 8; c++) begin
      if (c == 4) Reset_n = 1'b1;
      @(negedge Clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL midreset_nodone step %0d got done=%b busy=%b exp 0 0", c, done, busy);
      end
    end
    launch();
    for (int c = 1; c <= 471; c++) begin
      if (c == 470 || c == 471 || done !== 1'b0) begin
        checks++;
        if (done !== (c == 470) || busy !== (c == 470)) begin
          errors++;
          $display("FAIL midreset_restart cyc %0d got done=%b busy=%b exp %b %b",
                   c, done, busy, (c == 470), (c == 470));
        end
      end
      @(negedge Clk);
    end
  endtask

  initial begin
    Reset_n = 1'b0;
    start   = 1'b0;
    test_reset();
    test_timing();
    do_reset();
    test_addressing();
    do_reset();
    test_write_window();
    do_reset();
    test_ignored_start();
    do_reset();
    test_back_to_back();
    do_reset();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
